id_hazard: RTL and testbench
============================

# id_hazard

Hazard-detection unit in the ID stage that originates the two stall requests consumed by the pipeline stall controller. It detects load-use and branch-operand hazards against the instruction in EX, and holds ID for the full latency of an iterative divide through a small state machine. Outputs `stallreq_from_id1` / `stallreq_from_id2` connect directly to the stall controller; its `stall[5:0]` vector feeds back in.

## Interface
- `DIV_CYCLES`, 32: divide latency in cycles, legal range 2..64.
- `REG_AW`, 5: register-address width.

- `clk`  input  1  clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset (`RstEnable` = 1'b0).
- `stall`  input  6  stall vector from the stall controller; bit 2 = ID held.
- `id_reg1_read`, `id_reg2_read`  input  1  ID reads source operand 1 / 2.
- `id_reg1_addr`, `id_reg2_addr`  input  REG_AW  source addresses.
- `id_is_branch`  input  1  ID instruction resolves a branch in ID.
- `id_is_div`  input  1  ID instruction is a divide.
- `ex_wreg`  input  1  EX instruction writes a register.
- `ex_wd`  input  REG_AW  EX destination address.
- `ex_is_load`  input  1  EX instruction is a load.
- `stallreq_from_id1`  output  1  short front-end hold request.
- `stallreq_from_id2`  output  1  full front-end hold request (ID plus bubble into EX).
- `div_busy`  output  1  divider occupied (state BUSY).
- `div_start`  output  1  one-cycle registered pulse at divide start.

## Operation
- `match1` = `id_reg1_read & ex_wreg & (ex_wd != 0) & (ex_wd == id_reg1_addr)`; `match2` likewise. Register 0 never hazards.
- `lu_hit` = `ex_is_load & (match1 | match2)`.
- `br_hit` = `id_is_branch & ~ex_is_load & (match1 | match2)`.
- Divider FSM states: IDLE, BUSY, DONE; counter `cnt` of width clog2(DIV_CYCLES).
  - IDLE: if `id_is_div & ~lu_hit & ~stall[2]` -> BUSY, `cnt` <= DIV_CYCLES-1, `div_start` <= 1.
  - BUSY: `cnt` decrements each cycle; at `cnt == 0` -> DONE.
  - DONE: -> IDLE when `stall[2] == 0`; otherwise remain in DONE. DONE keeps the same divide, still in ID, from restarting.
- `div_req` = `(state == IDLE & id_is_div & ~lu_hit)` | `(state == BUSY)`.
- `stallreq_from_id2` = `lu_hit | div_req`.
- `stallreq_from_id1` = `br_hit & ~stallreq_from_id2`.
- `div_busy` = `(state == BUSY)`.
- Simultaneous `lu_hit` and `id_is_div`: the load-use stall is served first and the divide starts in the first cycle without `lu_hit`.
- A divide in ID while `stall[2]` is held by another source does not start. The stall request is still raised, and the divide starts once `stall[2]` drops.

## Timing
- Reset (async, `rst` = 0): state IDLE, `cnt` = 0, `div_start` = 0. All outputs read 0 while in reset. Reset mid-divide aborts immediately to IDLE.
- Stall requests are combinational from inputs and state, with zero-cycle latency.
- A divide first seen in cycle T gives:
  - `stallreq_from_id2` high for cycles T..T+DIV_CYCLES, which is DIV_CYCLES+1 cycles.
  - `div_start` high in T+1.
  - `div_busy` high for T+1..T+DIV_CYCLES.
  - Cycle T+DIV_CYCLES+1 is in DONE with requests low, so the divide leaves ID.
- Load-use and branch hazards hold only while the EX match persists. Normally this is 1 cycle, because EX advances under both stall patterns.
- `div_start` is never high in two consecutive cycles.

## Configuration
- `HAZ_DIV_EN` defined: divider FSM, counter, `div_busy`/`div_start` as specified.
- Not defined: no FSM or counter; `div_req` = 0; `div_busy` and `div_start` tied to 0; `id_is_div` ignored. Hazard logic is unchanged.

## Test plan
- Load-use: EX = load, wd=5, wreg=1; ID reads r5 on operand 2 -> `stallreq_from_id2`=1, `id1`=0 in that cycle; next cycle EX = bubble -> both 0.
- Register 0: EX = load, wd=0; ID reads r0 -> no request.
- Branch: EX = ALU, wd=7; ID branch reads r7 -> `stallreq_from_id1`=1 for one cycle, `id2`=0. The same case with EX = load -> `id2`=1, `id1`=0.
- Divide, DIV_CYCLES=4, `id_is_div` held from T, `stall[2]` follows `id2`:
  - `id2` high T..T+4.
  - `div_start` pulse at T+1.
  - `div_busy` high T+1..T+4.
  - DONE at T+5 with `id2`=0, then IDLE; no restart.
- Divide plus load-use in T -> `div_start` not pulsed at T+1. Hazard cleared at T+1 -> `div_start` at T+2.
- Async `rst` low at T+2 of a divide -> `div_busy`=0 and `id2`=0 immediately. Without `HAZ_DIV_EN`, a divide in ID -> no request.

Source files
------------

// File: rtl/id_hazard_if.sv
// Interface bundling the ID-stage hazard unit's pipeline-side signals.
// The master side (pipeline / stall controller) drives the operand, EX and
// stall information. The slave side (hazard unit) returns the stall requests
// and the divider status.
interface id_hazard_if #(
  parameter int REG_AW = 5
);
  logic [5:0]        stall;
  logic              id_reg1_read;
  logic              id_reg2_read;
  logic [REG_AW-1:0] id_reg1_addr;
  logic [REG_AW-1:0] id_reg2_addr;
  logic              id_is_branch;
  logic              id_is_div;
  logic              ex_wreg;
  logic [REG_AW-1:0] ex_wd;
  logic              ex_is_load;
  logic              stallreq_from_id1;
  logic              stallreq_from_id2;
  logic              div_busy;
  logic              div_start;

  modport master (
    output stall, id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr,
           id_is_branch, id_is_div, ex_wreg, ex_wd, ex_is_load,
    input  stallreq_from_id1, stallreq_from_id2, div_busy, div_start
  );

  modport slave (
    input  stall, id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr,
           id_is_branch, id_is_div, ex_wreg, ex_wd, ex_is_load,
    output stallreq_from_id1, stallreq_from_id2, div_busy, div_start
  );
endinterface

// File: rtl/id_hazard.sv
// ID-stage hazard detection unit.
// Raises the two front-end stall requests for the stall controller:
//   - load-use hazards against the instruction in EX,
//   - branch-operand hazards against a non-load instruction in EX,
//   - the full latency of an iterative divide (optional).
// Optional feature macro: HAZ_DIV_EN. When it is defined, a small
// IDLE/BUSY/DONE state machine holds ID for DIV_CYCLES+1 cycles per divide.
// When it is undefined, id_is_div is ignored and div_busy/div_start read 0.
// All outputs are forced low while rst (active-low, asynchronous) is asserted.
module id_hazard #(
  parameter int DIV_CYCLES = 32,
  parameter int REG_AW     = 5
) (
  input  logic       clk,
  input  logic       rst,
  id_hazard_if.slave hz
);

  logic match1_s;
  logic match2_s;
  logic lu_hit_s;
  logic br_hit_s;
  logic div_req_s;
  logic id2_raw_s;

  // Operand matches against EX destination; register 0 never hazards.
  always_comb begin
    match1_s = hz.id_reg1_read & hz.ex_wreg & (hz.ex_wd != {REG_AW{1'b0}}) &
               (hz.ex_wd == hz.id_reg1_addr);
    match2_s = hz.id_reg2_read & hz.ex_wreg & (hz.ex_wd != {REG_AW{1'b0}}) &
               (hz.ex_wd == hz.id_reg2_addr);
    lu_hit_s = hz.ex_is_load & (match1_s | match2_s);
    br_hit_s = hz.id_is_branch & ~hz.ex_is_load & (match1_s | match2_s);
  end

`ifdef HAZ_DIV_EN
  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t    state_r;
  div_state_t    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          div_start_r;
  logic          div_start_nxt_s;
  logic          unused_s;

  // Divider state, countdown and start pulse registers; reset aborts a divide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      div_start_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      div_start_r <= div_start_nxt_s;
    end
  end

  // Next-state logic: start only when no load-use hazard and ID is not held
  // elsewhere; DONE blocks the same divide from restarting while still in ID.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    div_start_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (hz.id_is_div & ~lu_hit_s & ~hz.stall[2]) begin
          state_nxt_s     = BUSY;
          cnt_nxt_s       = CW'(DIV_CYCLES - 1);
          div_start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = DONE;
        end else begin
          cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (!hz.stall[2]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Divide holds ID while waiting to start and for the whole busy phase.
  always_comb begin
    div_req_s = ((state_r == IDLE) & hz.id_is_div & ~lu_hit_s) | (state_r == BUSY);
  end

  assign hz.div_busy  = (state_r == BUSY);
  assign hz.div_start = div_start_r;
  assign unused_s     = &{1'b0, hz.stall[5:3], hz.stall[1:0]};
`else
  logic unused_s;

  // Without the divider there is never a divide stall.
  always_comb begin
    div_req_s = 1'b0;
  end

  assign hz.div_busy  = 1'b0;
  assign hz.div_start = 1'b0;
  assign unused_s     = &{1'b0, clk, hz.stall, hz.id_is_div};
`endif

  // Stall requests: full hold wins over the short branch hold; gated by reset.
  always_comb begin
    id2_raw_s               = lu_hit_s | div_req_s;
    hz.stallreq_from_id2    = rst & id2_raw_s;
    hz.stallreq_from_id1    = rst & br_hit_s & ~id2_raw_s;
  end

endmodule

// File: tb/tb_id_hazard.sv
// Directed-vector bench for id_hazard (DIV_CYCLES = 4).
// A driver applies one vector per cycle just after the rising edge and
// queues the hand-computed outputs; a monitor pops and compares them at the
// falling edge of the same cycle. Divider expectations follow HAZ_DIV_EN.
module tb_id_hazard;

`ifdef HAZ_DIV_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif

  typedef struct {
    logic id1;
    logic id2;
    logic busy;
    logic start;
    int   idx;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   chk_cnt;
  int   pass_cnt;
  int   vec_idx;

  id_hazard_if #(.REG_AW(5)) hz ();

  id_hazard #(.DIV_CYCLES(4), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic act, input logic req);
    chk_cnt = chk_cnt + 1;
    if (act === req) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s vec%0d: got %b expected %b", name, idx, act, req);
    end
  endtask

  // Monitor: compare the DUT outputs with the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stallreq_from_id1", e.idx, hz.stallreq_from_id1, e.id1);
      check("stallreq_from_id2", e.idx, hz.stallreq_from_id2, e.id2);
      check("div_busy",          e.idx, hz.div_busy,          e.busy);
      check("div_start",         e.idx, hz.div_start,         e.start);
    end
  end

  // One cycle of stimulus with its expected outputs.
  task automatic step(
    input logic       r,    input logic [5:0] st,
    input logic       r1rd, input logic [4:0] r1a,
    input logic       r2rd, input logic [4:0] r2a,
    input logic       br,   input logic       dv,
    input logic       wreg, input logic [4:0] wd,   input logic ld,
    input logic       e1,   input logic       e2,
    input logic       eb,   input logic       es
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    hz.stall        = st;
    hz.id_reg1_read = r1rd;
    hz.id_reg1_addr = r1a;
    hz.id_reg2_read = r2rd;
    hz.id_reg2_addr = r2a;
    hz.id_is_branch = br;
    hz.id_is_div    = dv;
    hz.ex_wreg      = wreg;
    hz.ex_wd        = wd;
    hz.ex_is_load   = ld;
    e.id1   = e1;
    e.id2   = e2;
    e.busy  = eb;
    e.start = es;
    e.idx   = vec_idx;
    vec_idx = vec_idx + 1;
    exp_q.push_back(e);
  endtask

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SH = 6'b000111;

  initial begin
    chk_cnt         = 0;
    pass_cnt        = 0;
    vec_idx         = 0;
    rst             = 1'b0;
    hz.stall        = S0;
    hz.id_reg1_read = 1'b0;
    hz.id_reg1_addr = 5'd0;
    hz.id_reg2_read = 1'b0;
    hz.id_reg2_addr = 5'd0;
    hz.id_is_branch = 1'b0;
    hz.id_is_div    = 1'b0;
    hz.ex_wreg      = 1'b0;
    hz.ex_wd        = 5'd0;
    hz.ex_is_load   = 1'b0;

    //   rst   stall r1rd r1a   r2rd r2a   br    dv    wreg  wd    ld      id1   id2   busy  start
    // In reset: a load-use pattern must still read all zeros.
    step(1'b0, S0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1,   1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, S0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);
    // Load-use on operand 2, then bubble in EX.
    step(1'b1, S0, 1'b1, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1,   1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, S0, 1'b1, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);
    // Register 0 never hazards.
    step(1'b1, S0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1,   1'b0, 1'b0, 1'b0, 1'b0);
    // Branch vs ALU in EX: short hold; then EX moves on.
    step(1'b1, S0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0,   1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, S0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);
    // Branch vs load in EX: full hold wins.
    step(1'b1, S0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1,   1'b0, 1'b1, 1'b0, 1'b0);
    // Load with no register write: no hazard.
    step(1'b1, S0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1,   1'b0, 1'b0, 1'b0, 1'b0);
    // Divide T..T+7 with ID held from T+1 through T+5.
    step(1'b1, S0, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    1'b0, 1'b0);
    step(1'b1, SH, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    E,    E   );
    step(1'b1, SH, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    E,    1'b0);
    step(1'b1, SH, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    E,    1'b0);
    step(1'b1, SH, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    E,    1'b0);
    step(1'b1, SH, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, S0, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, S0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);
    // Divide with load-use at T: start deferred to T+1, pulse at T+2; reset aborts.
    step(1'b1, S0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1,   1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, S0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    1'b0, 1'b0);
    step(1'b1, SH, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    E,    E   );
    step(1'b0, SH, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, S0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);
    // Divide while ID held by another source: requests but does not start.
    step(1'b1, SH, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    1'b0, 1'b0);
    step(1'b1, SH, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    1'b0, 1'b0);
    step(1'b1, S0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    1'b0, 1'b0);
    step(1'b1, SH, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,   1'b0, E,    E,    E   );
    step(1'b0, SH, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, S0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() > 0) begin
        @(posedge clk);
      end
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      chk_cnt = chk_cnt + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
